// File: rtl/cw_key_decoder.sv
// cw_key_decoder: Morse (CW) receive decoder. Synchronises and de-glitches a
// raw on/off key line, times marks and spaces in clock cycles, classifies
// each mark as dot or dash and reports one character per strobe plus a
// word-gap strobe.
module cw_key_decoder #(
    parameter int unsigned UNIT_CYC   = 1048576,
    parameter int unsigned GLITCH_CYC = 4096
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_in,
    output logic       key_f,
    output logic       char_valid,
    output logic [5:0] char_code,
    output logic [2:0] char_len,
    output logic       char_err,
    output logic       word_gap,
    output logic       busy
);

    localparam int unsigned CNT_MAX = 7 * UNIT_CYC;
    localparam int          CW      = $clog2(CNT_MAX + 1);
    localparam int          GW      = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;

    localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);
    localparam logic [CW-1:0] DASH_MIN = CW'(2 * UNIT_CYC);
    // Strobe decisions are taken one cycle early so the registered pulses
    // land exactly 2 and 5 units after the fall cycle.
    localparam logic [CW-1:0] CHAR_AT  = CW'(2 * UNIT_CYC - 1);
    localparam logic [CW-1:0] WORD_AT  = CW'(5 * UNIT_CYC - 1);
    localparam logic [GW-1:0] GLIM     = GW'(GLITCH_CYC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MARK  = 2'd1;
    localparam logic [1:0] ST_SPACE = 2'd2;

    logic          sync1_q, sync2_q;
    logic [GW-1:0] gcnt_q;
    logic          key_f_q, key_f_prev_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    state_q, state_d;
    logic [5:0]    code_q, code_d;
    logic [2:0]    len_q, len_d;
    logic          err_q, err_d;
    logic          wpend_q, wpend_d;
    logic          emit, wgap;
    logic          char_valid_q, char_err_q, word_gap_q;
    logic [5:0]    char_code_q;
    logic [2:0]    char_len_q;

    logic chg, rise, fall, dash;

    assign chg  = key_f_q ^ key_f_prev_q;
    assign rise = chg & key_f_q;
    assign fall = chg & ~key_f_q;
    assign dash = (cnt_q >= DASH_MIN);

    // Two-flop synchroniser, then the filtered key follows the synchronised
    // level only after it has differed for GLITCH_CYC consecutive cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            gcnt_q  <= '0;
            key_f_q <= 1'b0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            if (sync2_q == key_f_q) begin
                gcnt_q <= '0;
            end else if (gcnt_q == GLIM) begin
                gcnt_q  <= '0;
                key_f_q <= sync2_q;
            end else begin
                gcnt_q <= gcnt_q + GW'(1);
            end
        end
    end

    // Run counter: cycles since the last key_f change. In the change cycle
    // it still holds the full length of the run that just ended.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_f_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            key_f_prev_q <= key_f_q;
            if (chg)
                cnt_q <= CW'(1);
            else if (cnt_q != CNT_SAT)
                cnt_q <= cnt_q + CW'(1);
        end
    end

    // Element assembly and gap classification.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        len_d   = len_q;
        err_d   = err_q;
        wpend_d = wpend_q;
        emit    = 1'b0;
        wgap    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise)
                    state_d = ST_MARK;
            end
            ST_MARK: begin
                if (fall) begin
                    if (len_q == 3'd6) begin
                        err_d = 1'b1;
                    end else begin
                        code_d = code_q | (6'(dash) << len_q);
                        len_d  = len_q + 3'd1;
                    end
                    // A saturated count means the mark ran to 7 units or more.
                    if (cnt_q == CNT_SAT)
                        err_d = 1'b1;
                    state_d = ST_SPACE;
                end
            end
            ST_SPACE: begin
                // A rise wins over the gap decisions: a rise one cycle before
                // the character gap keeps the buffer for the same character.
                if (rise) begin
                    state_d = ST_MARK;
                end else if (cnt_q == CHAR_AT) begin
                    emit    = 1'b1;
                    code_d  = '0;
                    len_d   = '0;
                    err_d   = 1'b0;
                    wpend_d = 1'b1;
                end else if (cnt_q == WORD_AT) begin
                    wgap    = wpend_q;
                    wpend_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decoder state and element buffer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            wpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
            err_q   <= err_d;
            wpend_q <= wpend_d;
        end
    end

    // Registered strobes; character fields hold until the next strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            char_valid_q <= 1'b0;
            char_code_q  <= '0;
            char_len_q   <= '0;
            char_err_q   <= 1'b0;
            word_gap_q   <= 1'b0;
        end else begin
            char_valid_q <= emit;
            word_gap_q   <= wgap;
            if (emit) begin
                char_code_q <= code_q;
                char_len_q  <= len_q;
                char_err_q  <= err_q;
            end
        end
    end

    assign key_f      = key_f_q;
    assign char_valid = char_valid_q;
    assign char_code  = char_code_q;
    assign char_len   = char_len_q;
    assign char_err   = char_err_q;
    assign word_gap   = word_gap_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
